mmu_video_loader: RTL and testbench
===================================

# mmu_video_loader

MMU-side video fetch and load generator: the transmitting end of the shifter's DE/LOAD/data interface. While GLUE holds `de` high, it fetches one 16-bit screen word per 16-clock slot from memory at an auto-incrementing video address. It presents each word to the shifter under a 4-clock active-low `load_n` strobe. It sits between the memory arbiter and the `shifter` block and reproduces ST timing at 32 MHz: an 8 MHz ST cycle is 4 clocks, and the word rate is 2 MHz.

## Interface
- `LOAD_DELAY`, default 24: clocks from the first `de`-high sample to the first `load_n` fall (wakestate 1 = 24, 2 = 12, 3 = 20, 4 = 16). Legal range is 12 to 255.
- `CLOCK_32`  in  1  32 MHz system clock; all state updates on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `de`  in  1  display enable from GLUE, sampled synchronously.
- `vsync`  in  1  frame start, level; requests a reload of the video address from the base register.
- `base_we`  in  1  write strobe for the base register.
- `base_in`  in  23  new base word address (byte address bits 23:1).
- `mem_req`  out  1  word fetch request to the memory arbiter.
- `mem_addr`  out  23  word address of the current fetch.
- `mem_ack`  in  1  single-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  16  fetched screen word.
- `load_n`  out  1  active-low load strobe to the shifter.
- `data_out`  out  16  word presented to the shifter.
- `data_oe`  out  1  drive enable for `data_out`; equals `~load_n`.
- `underrun`  out  1  sticky flag: a fetch was not acknowledged in time. Cleared only by `RESET`.

## Operation
- **Reset values:** `load_n`=1, `data_oe`=0, `data_out`=0, `mem_req`=0, `mem_addr`=0, base register=0, `underrun`=0. The FSM enters IDLE.
- **FSM states:** IDLE, LEAD, SLOT.
  - IDLE → LEAD on the first clock with `de`=1.
  - LEAD counts `LOAD_DELAY-12` clocks, then enters SLOT at phase 0.
  - SLOT runs a 4-bit phase counter from 0 to 15.
  - At phase 15: if `de`=1, go to phase 0 of the next slot; otherwise go to IDLE.
  - `de` falling during LEAD returns the FSM to IDLE with no load issued.
- **Fetch, phases 0 to 11:**
  - `mem_req`=1 from phase 0 until the `mem_ack` cycle.
  - On `mem_ack`, latch `mem_data` into the hold register.
  - An ack arriving outside `mem_req` is ignored.
- **Underrun:** if no ack has arrived by the end of phase 11:
  - drop `mem_req`;
  - load 16'h0000 into the hold register;
  - set `underrun`.
- **Load, phases 12 to 15:**
  - `load_n`=0 and `data_oe`=1.
  - `data_out` = hold register, stable for all 4 clocks.
  - `data_out` keeps its last value after `load_n` rises.
- **Address:**
  - `mem_addr` increments by 1 word, modulo 2^23, at the end of every SLOT phase 15.
  - The increment happens whether the slot was acked or underran.
- **Reload:**
  - `vsync`=1 while in IDLE sets `mem_addr` ← base register.
  - `vsync` asserted during LEAD or SLOT is remembered and applied on the next entry to IDLE.
  - If a reload and a slot-end increment coincide, the reload wins.
- **Base register:** `base_we` writes the base register in any state; it does not affect `mem_addr` until the next reload. When `base_we` and a reload occur in the same clock, the reload uses the old base value.
- **Mid-operation `RESET`:** returns all state to reset values immediately. `load_n` deasserts asynchronously.

## Timing
- The first `load_n` fall occurs exactly `LOAD_DELAY` clocks after the first rising edge that samples `de`=1.
- Successive `load_n` falls are 16 clocks apart. Each low pulse lasts 4 clocks.
- Fetch latency budget: `mem_ack` must arrive by the end of phase 11, i.e. within 12 clocks of the `mem_req` rise.
- A slot in progress when `de` falls completes with its full 4-clock load. No slot starts after `de` is sampled low at phase 15.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `st_video_pkg`:**
  - constants `SLOT_LEN`=16, `FETCH_END`=11, `LOAD_START`=12, `ST_CYCLE`=4;
  - the FSM state enum;
  - word-address width 23.
- **Sub-module `video_addr_counter`:** base register, video address counter, reload/increment priority, and the pending-vsync flag. The FSM and phase counter stay in the top level.

## Test plan
- **Reset:** assert `RESET` mid-slot. Required response: `load_n`=1, `data_oe`=0, `mem_req`=0, `mem_addr`=0 and `underrun`=0 immediately, and the FSM is in IDLE.
- **Nominal fetch:** write base=23'h03C000, pulse `vsync`, raise `de`, ack 16'hAAAA 3 clocks after `mem_req`. Required response:
  - `load_n` falls 24 clocks after `de`, with `data_out`=16'hAAAA for 4 clocks;
  - the next fetch addresses 23'h03C001;
  - loads repeat every 16 clocks.
- **Underrun:** withhold `mem_ack` in one slot. Required response: `mem_req` drops after phase 11, `data_out`=16'h0000 during that load, `underrun`=1 (sticky), and the next slot's address is still incremented.
- **`de` falls mid-slot:** drop `de` at phase 5. Required response: the current slot still emits its 4-clock load, then no further `load_n` pulses.
- **`vsync` during a slot:** assert `vsync` during a slot with base changed to 23'h000100. Required response: `mem_addr` keeps incrementing until IDLE, then equals 23'h000100.
- **`LOAD_DELAY`=12:** raise `de`. Required response: `mem_req` rises on the clock after `de` is sampled, and `load_n` falls 12 clocks after the `de` sample.

Source files
------------

// File: rtl/st_video_pkg.sv
// Shared constants and state type for the MMU-side video fetch/load path.
// One slot is 16 clocks at 32 MHz. Fetch occupies phases 0-11 and load occupies phases 12-15.
package st_video_pkg;

    localparam int SLOT_LEN   = 16;
    localparam int ST_CYCLE   = 4;
    localparam int FETCH_END  = 11;
    localparam int LOAD_START = SLOT_LEN - ST_CYCLE;
    localparam int ADDR_W     = 23;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SLOT
    } state_t;

endpackage

// File: rtl/video_addr_counter.sv
// Holds the base register, the video word address and the deferred-vsync flag.
// When a reload and a slot-end increment fall on the same clock, the reload takes priority.
module video_addr_counter
    import st_video_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              base_we,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              vsync,
    input  logic              in_idle,
    input  logic              to_idle,
    input  logic              slot_end,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              pending_reg;
    logic              reload;

    // A vsync seen while busy is held and applied on the clock that returns the FSM to IDLE.
    assign reload = (in_idle && vsync) || (to_idle && (pending_reg || vsync));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg    <= '0;
            addr_reg    <= '0;
            pending_reg <= 1'b0;
        end else begin
            if (base_we)
                base_reg <= base_in;
            if (reload)
                addr_reg <= base_reg;
            else if (slot_end)
                addr_reg <= addr_reg + 1'b1;
            if (reload)
                pending_reg <= 1'b0;
            else if (!in_idle && vsync)
                pending_reg <= 1'b1;
        end
    end

    assign addr = addr_reg;

endmodule

// File: rtl/mmu_video_loader.sv
// Fetches one screen word per 16-clock slot while de is high. Each word is presented to the shifter under a 4-clock load_n strobe.
// Every output is computed from next-state values and then registered.
module mmu_video_loader
    import st_video_pkg::*;
#(
    parameter int LOAD_DELAY = 24
) (
    input  logic              CLOCK_32,
    input  logic              RESET,
    input  logic              de,
    input  logic              vsync,
    input  logic              base_we,
    input  logic [ADDR_W-1:0] base_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic              load_n,
    output logic [15:0]       data_out,
    output logic              data_oe,
    output logic              underrun
);

    localparam int         LEAD_CLKS  = LOAD_DELAY - LOAD_START;
    localparam logic [7:0] LEAD_LAST  = 8'((LEAD_CLKS > 0) ? LEAD_CLKS - 1 : 0);
    localparam logic [3:0] PH_LAST    = 4'(SLOT_LEN - 1);
    localparam logic [3:0] PH_FETCH   = 4'(FETCH_END);
    localparam logic [3:0] PH_LOAD    = 4'(LOAD_START);

    state_t      state_reg, state_next;
    logic [3:0]  phase_reg, phase_next;
    logic [7:0]  lead_cnt_reg, lead_cnt_next;
    logic        mem_req_reg, mem_req_next;
    logic        load_n_reg, load_n_next;
    logic        data_oe_reg, data_oe_next;
    logic [15:0] data_out_reg, data_out_next;
    logic [15:0] hold_reg, hold_next;
    logic        underrun_reg, underrun_next;
    logic        slot_start;

    always_ff @(posedge CLOCK_32 or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            lead_cnt_reg <= '0;
            mem_req_reg  <= 1'b0;
            load_n_reg   <= 1'b1;
            data_oe_reg  <= 1'b0;
            data_out_reg <= '0;
            hold_reg     <= '0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            lead_cnt_reg <= lead_cnt_next;
            mem_req_reg  <= mem_req_next;
            load_n_reg   <= load_n_next;
            data_oe_reg  <= data_oe_next;
            data_out_reg <= data_out_next;
            hold_reg     <= hold_next;
            underrun_reg <= underrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        lead_cnt_next = lead_cnt_reg;
        hold_next     = hold_reg;
        underrun_next = underrun_reg;
        mem_req_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (de) begin
                    phase_next    = '0;
                    lead_cnt_next = '0;
                    state_next    = (LEAD_CLKS == 0) ? SLOT : LEAD;
                end
            end
            LEAD: begin
                if (!de)
                    state_next = IDLE;
                else if (lead_cnt_reg == LEAD_LAST) begin
                    state_next = SLOT;
                    phase_next = '0;
                end else
                    lead_cnt_next = lead_cnt_reg + 8'd1;
            end
            SLOT: begin
                phase_next = phase_reg + 4'd1;
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    state_next = de ? SLOT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The fetch closes on ack, or at the end of phase 11 with a zero word if no ack has come.
        if (state_reg == SLOT && mem_req_reg) begin
            if (mem_ack)
                hold_next = mem_data;
            else if (phase_reg == PH_FETCH) begin
                hold_next     = '0;
                underrun_next = 1'b1;
            end else
                mem_req_next = 1'b1;
        end

        slot_start = (state_next == SLOT) && (phase_next == 4'd0);
        if (slot_start)
            mem_req_next = 1'b1;

        data_oe_next  = (state_next == SLOT) && (phase_next >= PH_LOAD);
        load_n_next   = !data_oe_next;
        data_out_next = data_out_reg;
        if (state_next == SLOT && phase_next == PH_LOAD)
            data_out_next = hold_next;
    end

    video_addr_counter u_addr (
        .clk      (CLOCK_32),
        .rst      (RESET),
        .base_we  (base_we),
        .base_in  (base_in),
        .vsync    (vsync),
        .in_idle  (state_reg == IDLE),
        .to_idle  ((state_reg != IDLE) && (state_next == IDLE)),
        .slot_end ((state_reg == SLOT) && (phase_reg == PH_LAST)),
        .addr     (mem_addr)
    );

    assign mem_req  = mem_req_reg;
    assign load_n   = load_n_reg;
    assign data_oe  = data_oe_reg;
    assign data_out = data_out_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_mmu_video_loader.sv
// Scoreboard bench for mmu_video_loader. Stimulus queues the expected loads, and a monitor checks each load_n pulse.
module tb_mmu_video_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0, vsync = 1'b0, base_we = 1'b0;
    logic [22:0] base_in = '0;
    logic        mem_req, mem_ack = 1'b0;
    logic [22:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        load_n, data_oe, underrun;
    logic [15:0] data_out;

    logic        de12 = 1'b0, ack12 = 1'b0;
    logic [15:0] data12 = '0;
    logic        mem_req12, load_n12, data_oe12, underrun12;
    logic [22:0] mem_addr12;
    logic [15:0] data_out12;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { logic [15:0] data; logic [22:0] addr; int at; } exp_t;
    typedef struct { logic [15:0] word; int delay; } rsp_t;
    exp_t exp_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmu_video_loader dut (
        .CLOCK_32(clk), .RESET(rst), .de(de), .vsync(vsync), .base_we(base_we), .base_in(base_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .load_n(load_n), .data_out(data_out), .data_oe(data_oe), .underrun(underrun)
    );

    mmu_video_loader #(.LOAD_DELAY(12)) dut12 (
        .CLOCK_32(clk), .RESET(rst), .de(de12), .vsync(vsync), .base_we(base_we), .base_in(base_in),
        .mem_req(mem_req12), .mem_addr(mem_addr12), .mem_ack(ack12), .mem_data(data12),
        .load_n(load_n12), .data_out(data_out12), .data_oe(data_oe12), .underrun(underrun12)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_load(logic [15:0] d, logic [22:0] a, int at);
        exp_t e;
        e.data = d; e.addr = a; e.at = at;
        exp_q.push_back(e);
    endfunction

    function automatic void add_rsp(logic [15:0] w, int dly);
        rsp_t r;
        r.word = w; r.delay = dly;
        rsp_q.push_back(r);
    endfunction

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Memory model: delay N raises mem_ack during the Nth clock of mem_req. Delay 0 withholds the ack.
    initial begin
        int   req_cnt;
        bit   acked;
        rsp_t cur;
        req_cnt = 0; acked = 0; cur.word = '0; cur.delay = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (!acked) begin
                    if (req_cnt == 0) begin
                        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
                        else begin cur.word = '0; cur.delay = 0; end
                    end
                    req_cnt++;
                    if (cur.delay != 0 && req_cnt == cur.delay) begin
                        mem_ack = 1'b1; mem_data = cur.word; acked = 1;
                    end
                end else
                    mem_ack = 1'b0;
            end else begin
                mem_ack = 1'b0; req_cnt = 0; acked = 0;
            end
        end
    end

    // Monitor: on each load_n fall, check the word, timing and fetch address. Also check hold and pulse width.
    initial begin
        logic        load_n_prev, mem_req_prev;
        logic [22:0] fetch_addr;
        logic [15:0] held;
        int          low_cnt;
        exp_t        e;
        load_n_prev = 1'b1; mem_req_prev = 1'b0; fetch_addr = '0; held = '0; low_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req && !mem_req_prev) fetch_addr = mem_addr;
                if (load_n_prev && !load_n) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL load_unexpected: load_n fell at cycle %0d with data %0h, expected none", cyc, data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("load_data", data_out, e.data);
                        check("load_cycle", cyc, e.at);
                        check("fetch_addr", fetch_addr, e.addr);
                    end
                    low_cnt = 1; held = data_out;
                    check("data_oe_on", data_oe, 1);
                end else if (!load_n) begin
                    low_cnt++;
                    check("load_hold", data_out, held);
                    check("data_oe_on", data_oe, 1);
                end else if (!load_n_prev) begin
                    check("load_width", low_cnt, 4);
                    check("data_oe_off", data_oe, 0);
                end
            end
            load_n_prev = load_n;
            mem_req_prev = mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, c2, c3;
        logic [15:0] nom_data [5];
        int          nom_dly  [5];
        nom_data = '{16'hAAAA, 16'h5555, 16'h1234, 16'h0000, 16'hBEEF};
        nom_dly  = '{3, 5, 12, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_load_n", load_n, 1);
        check("rst_data_oe", data_oe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Base write, then a vsync in IDLE reloads the address.
        base_we = 1'b1; base_in = 23'h03C000;
        @(negedge clk); base_we = 1'b0; vsync = 1'b1;
        @(negedge clk); vsync = 1'b0;
        check("reload_idle", mem_addr, 23'h03C000);

        // Nominal stream: slot 2 acks at phase 11, slot 3 underruns, and de drops at phase 5 of slot 4.
        for (int i = 0; i < 5; i++) add_rsp(nom_data[i], nom_dly[i]);
        @(negedge clk); de = 1'b1; c0 = cyc + 1;
        for (int i = 0; i < 5; i++) expect_load(nom_data[i], 23'h03C000 + 23'(i), c0 + 24 + 16 * i);
        wait_until(c0 + 71);
        check("underrun_req_ph11", mem_req, 1);
        check("underrun_clear", underrun, 0);
        wait_until(c0 + 72);
        check("underrun_req_drop", mem_req, 0);
        check("underrun_set", underrun, 1);
        wait_until(c0 + 81); de = 1'b0;
        wait_until(c0 + 100);
        check("addr_after_stream", mem_addr, 23'h03C005);
        check("data_out_retained", data_out, 16'hBEEF);
        check("underrun_sticky", underrun, 1);
        check("idle_mem_req", mem_req, 0);
        wait_until(c0 + 130);
        check("exp_drained_1", exp_q.size(), 0);

        // A vsync raised during a slot is deferred until the FSM returns to IDLE.
        base_we = 1'b1; base_in = 23'h000100;
        @(negedge clk); base_we = 1'b0;
        check("base_no_effect", mem_addr, 23'h03C005);
        add_rsp(16'h1111, 2); add_rsp(16'h2222, 4);
        @(negedge clk); de = 1'b1; c1 = cyc + 1;
        expect_load(16'h1111, 23'h03C005, c1 + 24);
        expect_load(16'h2222, 23'h03C006, c1 + 40);
        wait_until(c1 + 20); vsync = 1'b1;
        @(negedge clk); vsync = 1'b0;
        wait_until(c1 + 33); de = 1'b0;
        wait_until(c1 + 43);
        check("addr_during_slot", mem_addr, 23'h03C006);
        wait_until(c1 + 46);
        check("reload_after_idle", mem_addr, 23'h000100);
        wait_until(c1 + 70);
        check("exp_drained_2", exp_q.size(), 0);

        // With the minimum load delay, there is no lead phase.
        @(negedge clk);
        check("d12_req_idle", mem_req12, 0);
        de12 = 1'b1; c2 = cyc + 1;
        wait_until(c2);
        check("d12_req_rise", mem_req12, 1);
        wait_until(c2 + 11);
        check("d12_load_n_before", load_n12, 1);
        wait_until(c2 + 12);
        check("d12_load_n_fall", load_n12, 0);
        check("d12_data_oe", data_oe12, 1);
        de12 = 1'b0;
        wait_until(c2 + 24);

        // Reset asserted during a load pulse clears all outputs at once.
        add_rsp(16'hCAFE, 2);
        @(negedge clk); de = 1'b1; c3 = cyc + 1;
        expect_load(16'hCAFE, 23'h000100, c3 + 24);
        wait_until(c3 + 14); de = 1'b0;
        wait_until(c3 + 26);
        check("pre_reset_load_n", load_n, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_load_n", load_n, 1);
        check("mid_rst_data_oe", data_oe, 0);
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_data_out", data_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle_req", mem_req, 0);
        check("post_rst_idle_load", load_n, 1);
        check("post_rst_addr", mem_addr, 0);
        check("exp_drained_3", exp_q.size(), 0);
        check("rsp_drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
